// File: rtl/fence_ctrl.sv
// Memory-ordering sequencer for FENCE / FENCE.I. It stalls the front end until the
// LSU drains, and for FENCE.I it also invalidates the I-cache, then flushes and redirects to pc+4.

typedef enum logic [1:0] {
    fk_fence   = 2'd0,
    fk_fence_i = 2'd1,
    fk_invalid = 2'd2
} fence_kind_t;

module fence_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  fence_kind_t       req_kind,
    input  logic [XLEN-1:0]   req_pc,
    output logic              req_ready,
    input  logic              sb_empty,
    input  logic              lsu_idle,
    output logic              ic_inv_req,
    input  logic              ic_inv_ack,
    output logic              stall,
    output logic              flush,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              retire,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_INV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            is_i_q, is_i_d;
    logic            accept;
    logic            is_fence_kind;

    assign accept        = req_valid && req_ready;
    assign is_fence_kind = (req_kind == fk_fence) || (req_kind == fk_fence_i);

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        pc_d      = pc_q;
        is_i_d    = is_i_q;

        if (accept) begin
            pc_d   = req_pc;
            is_i_d = (req_kind == fk_fence_i);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_fence_kind) begin
                        state_d = S_DRAIN;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // An ack arriving with the drain is dropped; INV waits for its own ack.
                if (sb_empty && lsu_idle) begin
                    state_d = is_i_q ? S_INV : S_FINISH;
                end
            end
            S_INV: begin
                if (ic_inv_ack) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // The PC and kind are only consumed in states reachable after an accept.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        is_i_q <= is_i_d;
    end

    always_comb begin
        req_ready   = rst && (state_q == S_IDLE);
        stall       = (state_q != S_IDLE);
        ic_inv_req  = (state_q == S_INV);
        retire      = (state_q == S_FINISH);
        flush       = (state_q == S_FINISH) && is_i_q;
        illegal     = illegal_q;
        redirect_pc = '0;
        if (flush) begin
            redirect_pc = pc_q + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_fence_ctrl.sv
// Directed bench for fence_ctrl: every cycle's expected outputs are queued with the
// stimulus and checked just after the clock edge.

module tb_fence_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    fence_kind_t req_kind;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        sb_empty;
    logic        lsu_idle;
    logic        ic_inv_req;
    logic        ic_inv_ack;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        retire;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [5:0]  ctrl;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];

    fence_ctrl #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_kind    (req_kind),
        .req_pc      (req_pc),
        .req_ready   (req_ready),
        .sb_empty    (sb_empty),
        .lsu_idle    (lsu_idle),
        .ic_inv_req  (ic_inv_req),
        .ic_inv_ack  (ic_inv_ack),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .retire      (retire),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl bits: {req_ready, stall, ic_inv_req, flush, retire, illegal}
    task automatic cyc(input string tag, input logic r, input logic v, input fence_kind_t k,
                       input logic [31:0] pc, input logic sbe, input logic idle, input logic ack,
                       input logic [5:0] exp_ctrl, input logic [31:0] exp_pc);
        exp_t e;
        logic [5:0] got;
        rst        = r;
        req_valid  = v;
        req_kind   = k;
        req_pc     = pc;
        sb_empty   = sbe;
        lsu_idle   = idle;
        ic_inv_ack = ack;
        sb_q.push_back('{tag, exp_ctrl, exp_pc});
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = {req_ready, stall, ic_inv_req, flush, retire, illegal};
        n_checks++;
        assert (got === e.ctrl) else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%b expected=%b", e.tag, got, e.ctrl);
        end
        n_checks++;
        assert (redirect_pc === e.pc) else begin
            n_fail++;
            $error("FAIL %s redirect_pc observed=%h expected=%h", e.tag, redirect_pc, e.pc);
        end
    endtask

    localparam logic [5:0] IDLE_C   = 6'b100000;
    localparam logic [5:0] RST_C    = 6'b000000;
    localparam logic [5:0] DRAIN_C  = 6'b010000;
    localparam logic [5:0] INV_C    = 6'b011000;
    localparam logic [5:0] FIN_C    = 6'b010010;
    localparam logic [5:0] FINI_C   = 6'b010110;
    localparam logic [5:0] ILL_C    = 6'b100001;

    initial begin
        // Reset; a stray ack while idle must be ignored.
        cyc("rst0",       0, 0, fk_fence,   32'h0,         1, 1, 0, RST_C,  32'h0);
        cyc("rst1",       0, 1, fk_fence,   32'h0,         1, 1, 0, RST_C,  32'h0);
        cyc("rst_rel",    1, 0, fk_fence,   32'h0,         1, 1, 1, IDLE_C, 32'h0);

        // FENCE with LSU already drained.
        cyc("f1_acc",     1, 1, fk_fence,   32'h100,       1, 1, 0, DRAIN_C, 32'h0);
        cyc("f1_fin",     1, 0, fk_fence,   32'h0,         1, 1, 0, FIN_C,   32'h0);
        cyc("f1_idle",    1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        // FENCE held in DRAIN by a non-empty store buffer; requests during DRAIN ignored.
        cyc("f2_acc",     1, 1, fk_fence,   32'h180,       0, 1, 0, DRAIN_C, 32'h0);
        for (int i = 0; i < 4; i++)
            cyc("f2_wait",    1, 1, fk_fence_i, 32'h999,   0, 1, 1, DRAIN_C, 32'h0);
        cyc("f2_lsu",     1, 0, fk_fence,   32'h0,         1, 0, 0, DRAIN_C, 32'h0);
        cyc("f2_fin",     1, 0, fk_fence,   32'h0,         1, 1, 0, FIN_C,   32'h0);
        cyc("f2_idle",    1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        // FENCE.I with ack three cycles into INV.
        cyc("fi1_acc",    1, 1, fk_fence_i, 32'h200,       1, 1, 0, DRAIN_C, 32'h0);
        cyc("fi1_inv1",   1, 0, fk_fence,   32'h0,         1, 1, 0, INV_C,   32'h0);
        cyc("fi1_inv2",   1, 0, fk_fence,   32'h0,         1, 1, 0, INV_C,   32'h0);
        cyc("fi1_inv3",   1, 0, fk_fence,   32'h0,         1, 1, 0, INV_C,   32'h0);
        cyc("fi1_fin",    1, 0, fk_fence,   32'h0,         1, 1, 1, FINI_C,  32'h204);
        cyc("fi1_idle",   1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        // FENCE.I at top of address space, ack on the first INV cycle -> wrap to 0.
        cyc("fi2_acc",    1, 1, fk_fence_i, 32'hFFFF_FFFC, 1, 1, 0, DRAIN_C, 32'h0);
        cyc("fi2_inv",    1, 0, fk_fence,   32'h0,         1, 1, 0, INV_C,   32'h0);
        cyc("fi2_fin",    1, 0, fk_fence,   32'h0,         1, 1, 1, FINI_C,  32'h0);
        cyc("fi2_idle",   1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        // Ack coincident with drain is not latched; INV waits for a fresh ack.
        cyc("fi3_acc",    1, 1, fk_fence_i, 32'h400,       0, 1, 0, DRAIN_C, 32'h0);
        cyc("fi3_drack",  1, 0, fk_fence,   32'h0,         1, 1, 1, INV_C,   32'h0);
        cyc("fi3_noack",  1, 0, fk_fence,   32'h0,         1, 1, 0, INV_C,   32'h0);
        cyc("fi3_fin",    1, 0, fk_fence,   32'h0,         1, 1, 1, FINI_C,  32'h404);
        cyc("fi3_idle",   1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        // Back-to-back invalid requests give consecutive illegal pulses, no stall.
        cyc("ill_1",      1, 1, fk_invalid, 32'h500,       1, 1, 0, ILL_C,   32'h0);
        cyc("ill_2",      1, 1, fk_invalid, 32'h504,       1, 1, 0, ILL_C,   32'h0);
        cyc("ill_end",    1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        // Reset while in INV, then a late ack, then a plain FENCE.
        cyc("rinv_acc",   1, 1, fk_fence_i, 32'h300,       1, 1, 0, DRAIN_C, 32'h0);
        cyc("rinv_inv",   1, 0, fk_fence,   32'h0,         1, 1, 0, INV_C,   32'h0);
        cyc("rinv_rst",   0, 0, fk_fence,   32'h0,         1, 1, 0, RST_C,   32'h0);
        cyc("rinv_late",  1, 0, fk_fence,   32'h0,         1, 1, 1, IDLE_C,  32'h0);
        cyc("f3_acc",     1, 1, fk_fence,   32'h100,       1, 1, 0, DRAIN_C, 32'h0);
        cyc("f3_fin",     1, 0, fk_fence,   32'h0,         1, 1, 0, FIN_C,   32'h0);
        cyc("f3_idle",    1, 0, fk_fence,   32'h0,         1, 1, 0, IDLE_C,  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fence_ctrl.md
# fence_ctrl

Sequencer for RV32I memory-ordering instructions in the kakacpu core. Accepts a fence-class instruction from decode, already classified by `decode_fence` into `fence_kind_t`. For FENCE it stalls the front end until the LSU has drained. For FENCE.I it additionally runs an I-cache invalidate handshake, then flushes the pipeline and redirects fetch to pc+4. Sits between decode, the LSU/store buffer and the fetch unit.

## Interface
- `XLEN`, default 32: PC width.

- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  decode presents a fence-class instruction.
- `req_kind`  in  `fence_kind_t`  `fk_fence`, `fk_fence_i` or `fk_invalid`.
- `req_pc`  in  XLEN  PC of the presented instruction.
- `req_ready`  out  1  controller idle; a request is accepted when `req_valid && req_ready`.
- `sb_empty`  in  1  store buffer holds no pending stores.
- `lsu_idle`  in  1  no outstanding loads or stores in the LSU.
- `ic_inv_req`  out  1  I-cache invalidate-all request, level.
- `ic_inv_ack`  in  1  I-cache invalidate complete, one-cycle pulse.
- `stall`  out  1  hold fetch/decode.
- `flush`  out  1  one-cycle pipeline flush pulse.
- `redirect_pc`  out  XLEN  fetch target; meaningful only while `flush`=1.
- `retire`  out  1  one-cycle pulse: fence instruction completes.
- `illegal`  out  1  one-cycle pulse: accepted request had `fk_invalid`.

## Operation
- FSM states: IDLE, DRAIN, INV, FINISH. Reset state is IDLE.
- On accept, latch `req_pc` into `pc_q` and record `is_i` = (`req_kind == fk_fence_i`).
- **IDLE**
  - `req_ready`=1.
  - Accept of `fk_fence` or `fk_fence_i` -> DRAIN.
  - Accept of `fk_invalid` -> stay in IDLE; `illegal` pulses on the next cycle.
- **DRAIN**
  - `stall`=1.
  - When `sb_empty && lsu_idle` is sampled high: go to INV if `is_i`, else FINISH.
  - Otherwise remain. There is no timeout.
- **INV**
  - `stall`=1, `ic_inv_req`=1, held continuously until `ic_inv_ack` is sampled high, then -> FINISH.
  - `ic_inv_ack` in any other state is ignored.
- **FINISH** (exactly one cycle, then -> IDLE)
  - `stall`=1, `retire`=1.
  - If `is_i`: `flush`=1 and `redirect_pc = pc_q + 4`, computed modulo 2^XLEN so 0xFFFF_FFFC wraps to 0x0000_0000.
- Plain FENCE never asserts `flush` or `ic_inv_req`.
- Only one fence is in flight at a time; `req_valid` outside IDLE is not accepted and has no effect.
- `pc_q` and `is_i` change only on accept.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs, except that `rst` gates `req_ready`.
- Reset values while `rst`=0 and on the first cycle after reset:
  - `stall`, `flush`, `retire`, `illegal`, `ic_inv_req` = 0.
  - `redirect_pc` = 0.
  - `req_ready` = 0 while `rst`=0; 1 on the first cycle with `rst`=1.
- Reset mid-operation, in any state: the next edge with `rst`=0 returns to IDLE and drops `ic_inv_req`, `stall`, `flush`, `retire`. A pending ack is discarded.
- FENCE latency, with the LSU already drained: accept at cycle T; DRAIN at T+1; FINISH/`retire` at T+2; `req_ready`=1 again at T+3.
- FENCE.I latency: accept at T; DRAIN at T+1; INV at T+2 with `ic_inv_req`=1. An ack at T+2 is legal and gives FINISH at T+3; generally FINISH = first ack cycle + 1.
- `stall` is high from T+1 through FINISH inclusive.
- `illegal`: accept at T, pulse at T+1. `req_ready` stays 1 throughout, so back-to-back invalid requests give consecutive pulses.
- Drain and ack both high in the same DRAIN cycle: only the drain is consumed. The ack is not latched, and INV waits for a fresh ack.

## Test plan
- Reset, then FENCE at pc=0x100 with `sb_empty`=`lsu_idle`=1 -> `stall` high for 2 cycles, `retire` at T+2, `flush`=0, `ic_inv_req` never high.
- FENCE with `sb_empty`=0 for 5 cycles, then 1 -> remains in DRAIN; `retire` exactly 1 cycle after the drain condition is sampled.
- FENCE.I at pc=0x200, ack returned 3 cycles after `ic_inv_req` rises -> `ic_inv_req` held high 3 cycles then dropped; `flush`=`retire`=1 for one cycle with `redirect_pc`=0x204.
- FENCE.I at pc=0xFFFF_FFFC, ack on the same cycle as req -> `redirect_pc`=0x0000_0000, FINISH at T+3.
- `fk_invalid` on two consecutive cycles -> `illegal` pulses at T+1 and T+2, `stall` stays 0.
- Assert `rst`=0 while in INV -> next cycle `ic_inv_req`=0, `stall`=0, `req_ready`=0. After release, a late `ic_inv_ack` is ignored and the next FENCE behaves as in test 1.
